seg7_sample_decoder: RTL

- Receive-side counterpart of the dice/digit 7-segment encoder: samples an 8-bit segment bus (gfedcba in bits [6:0], decimal point in bit 7) and recovers the displayed digit and value.
- Filters glitches with a stability counter, emits each newly settled pattern once over a valid/ready output, and flags and counts illegal patterns.
- Sits on ui_in, so a second board or loopback can check the encoder's uo_out.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_pattern_lut.sv | 40 ++++
 rtl/seg7_sample_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and helpers for the 7-segment sample decoder.
// Patterns are gfedcba in bits [6:0]; bit 7 is the decimal point.
package seg7_pkg;

    typedef logic [7:0] seg_t;
    typedef logic [3:0] digit_t;
    typedef logic [4:0] dice_val_t;

    typedef enum logic {WAIT, SETTLE} state_t;
    typedef enum logic [1:0] {BLANK, LEGAL, ILLEGAL} pat_class_t;

    localparam seg_t SEG_BLANK = 8'h00;

    localparam logic [6:0] DIGIT_SEGS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // A, b, C, d, E, F
    localparam logic [6:0] HEX_SEGS [6] = '{
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Dice value: a bare 0 stands for 10, and the decimal point adds ten.
    function automatic dice_val_t dice_value(input digit_t d, input logic with_dp);
        if (d == 4'd0)
            return with_dp ? 5'd20 : 5'd10;
        return with_dp ? (dice_val_t'(d) + 5'd10) : dice_val_t'(d);
    endfunction

endpackage

// File: rtl/seg7_pattern_lut.sv
// Combinational classifier: segment byte -> class, digit, dp, dice value.
// Hex letters A-F (dp clear) are legal only when SEG7_DEC_HEX_EN is defined.
module seg7_pattern_lut
    import seg7_pkg::*;
(
    input  seg_t       seg,
    output pat_class_t cls,
    output digit_t     digit,
    output logic       dp,
    output dice_val_t  value
);

    always_comb begin
        cls   = ILLEGAL;
        digit = '0;
        value = '0;
        dp    = seg[7];
        if (seg == SEG_BLANK) begin
            cls = BLANK;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (seg[6:0] == DIGIT_SEGS[i]) begin
                    cls   = LEGAL;
                    digit = digit_t'(i);
                    value = dice_value(digit_t'(i), seg[7]);
                end
            end
`ifdef SEG7_DEC_HEX_EN
            for (int i = 0; i < 6; i++) begin
                if (seg == {1'b0, HEX_SEGS[i]}) begin
                    cls   = LEGAL;
                    digit = digit_t'(i + 10);
                    value = '0;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/seg7_sample_decoder.sv
// Samples a 7-segment bus, debounces it, and emits each newly settled digit
// once over valid/ready. Optional hex letters: define SEG7_DEC_HEX_EN.
module seg7_sample_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           seg_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [3:0]           digit,
    output logic                 dp,
    output logic [4:0]           value,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 overrun
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACCEPT_AT  = 8'(STABLE_CYCLES - 1);

    seg_t       seg_q;
    seg_t       last_pattern;
    logic [7:0] stable_cnt;
    state_t     state;

    pat_class_t lut_cls;
    digit_t     lut_digit;
    logic       lut_dp;
    dice_val_t  lut_value;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    seg7_pattern_lut u_lut (
        .seg   (seg_q),
        .cls   (lut_cls),
        .digit (lut_digit),
        .dp    (lut_dp),
        .value (lut_value)
    );

    // stable_cnt counts repeats of seg_q beyond its first sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q      <= '0;
            stable_cnt <= '0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q)
                stable_cnt <= '0;
            else if (stable_cnt < STABLE_MAX)
                stable_cnt <= stable_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT;
            last_pattern <= '0;
            out_valid    <= 1'b0;
            digit        <= '0;
            dp           <= 1'b0;
            value        <= '0;
            err          <= 1'b0;
            err_cnt      <= '0;
            overrun      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                WAIT: begin
                    if (seg_q != last_pattern)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (seg_q == last_pattern) begin
                        state <= WAIT;
                    end else if (stable_cnt >= ACCEPT_AT) begin
                        state        <= WAIT;
                        last_pattern <= seg_q;
                        case (lut_cls)
                            LEGAL: begin
                                out_valid <= 1'b1;
                                digit     <= lut_digit;
                                dp        <= lut_dp;
                                value     <= lut_value;
                                if (out_valid && !out_ready)
                                    overrun <= 1'b1;
                            end
                            ILLEGAL: begin
                                err     <= 1'b1;
                                err_cnt <= sat_inc(err_cnt);
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule
